// File: rtl/seqdiv8.sv
// Sequential 8-bit non-restoring divider: one quotient bit per RUN cycle, then a FIX cycle.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned only.
module seqdiv8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] quo,
    output logic [7:0] rem,
    output logic       busy,
    output logic       done,
    output logic       dz,
    output logic       ovl
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [8:0] prem_q, prem_d;   // signed partial remainder
    logic [7:0] qsh_q, qsh_d;     // dividend shifting out, quotient shifting in
    logic [7:0] dvs_q, dvs_d;     // divisor magnitude
    logic       zero_q, zero_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dz_q, dz_d;

    logic [7:0] a_mag, b_mag;
    logic       sub;
    logic [8:0] opnd, addsub, prem_fix;

`ifdef DIV_SIGNED_EN
    logic       sa_q, sa_d;       // dividend negative: remainder sign
    logic       sq_q, sq_d;       // operand signs differ: quotient sign
    logic       ovl_q, ovl_d;

    assign a_mag = a[7] ? (~a + 8'd1) : a;
    assign b_mag = b[7] ? (~b + 8'd1) : b;
    assign ovl   = ovl_q;
`else
    assign a_mag = a;
    assign b_mag = b;
    assign ovl   = 1'b0;
`endif

    // Sign of the partial remainder picks subtract (non-negative) or add (negative).
    assign sub      = ~prem_q[8];
    assign opnd     = sub ? ~{1'b0, dvs_q} : {1'b0, dvs_q};
    assign addsub   = {prem_q[7:0], qsh_q[7]} + opnd + {8'd0, sub};
    assign prem_fix = prem_q[8] ? (prem_q + {1'b0, dvs_q}) : prem_q;

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign dz   = dz_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        // NOTE: every signal gets its hold value first so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        qsh_d   = qsh_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        sa_d    = sa_q;
        sq_d    = sq_q;
        ovl_d   = ovl_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = 3'd0;
                    prem_d  = 9'd0;
                    dvs_d   = b_mag;
                    zero_d  = (b == 8'd0);
                    // A zero divisor keeps the raw dividend so FIX can return it as rem.
                    qsh_d   = (b == 8'd0) ? a : a_mag;
                    state_d = (b == 8'd0) ? FIX : RUN;
`ifdef DIV_SIGNED_EN
                    sa_d    = a[7];
                    sq_d    = a[7] ^ b[7];
`endif
                end
            end
            RUN: begin
                prem_d = addsub;
                qsh_d  = {qsh_q[6:0], ~addsub[8]};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                if (zero_q) begin
                    quo_d = 8'hFF;
                    rem_d = qsh_q;
                    dz_d  = 1'b1;
`ifdef DIV_SIGNED_EN
                    ovl_d = 1'b0;
`endif
                end else begin
                    prem_d = prem_fix;
                    dz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                    quo_d  = sq_q ? (~qsh_q + 8'd1) : qsh_q;
                    rem_d  = sa_q ? (~prem_fix[7:0] + 8'd1) : prem_fix[7:0];
                    // Only -128 / -1 yields a positive magnitude of 128.
                    ovl_d  = ~sq_q & qsh_q[7];
`else
                    quo_d  = qsh_q;
                    rem_d  = prem_fix[7:0];
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the few datapath registers are small flops, so all of them share the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            prem_q  <= 9'd0;
            qsh_q   <= 8'd0;
            dvs_q   <= 8'd0;
            zero_q  <= 1'b0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            sa_q    <= 1'b0;
            sq_q    <= 1'b0;
            ovl_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            qsh_q   <= qsh_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
            sa_q    <= sa_d;
            sq_q    <= sq_d;
            ovl_q   <= ovl_d;
`endif
        end
    end

endmodule

// File: tb/tb_seqdiv8.sv
// Self-checking bench for seqdiv8: directed and random divisions against an arithmetic model.
module tb_seqdiv8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic [7:0] quo, rem;
    logic       busy, done, dz, ovl;

    int n_checks = 0;
    int n_fail   = 0;

    seqdiv8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .quo   (quo),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ovl   (ovl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of the result.
    task automatic model(input logic [7:0] ta, input logic [7:0] tb_v,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output logic o);
        int x, y, qi, ri;
`ifdef DIV_SIGNED_EN
        x = int'($signed(ta));
        y = int'($signed(tb_v));
`else
        x = int'(ta);
        y = int'(tb_v);
`endif
        if (y == 0) begin
            q = 8'hFF; r = ta; z = 1'b1; o = 1'b0;
        end else begin
            qi = x / y;
            ri = x % y;
            q = qi[7:0]; r = ri[7:0]; z = 1'b0;
`ifdef DIV_SIGNED_EN
            o = (qi == 128);
`else
            o = 1'b0;
`endif
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns #1 after the edge back into IDLE.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input string tag);
        int cyc, busy_n, exp_lat;
        logic [7:0] eq, er;
        logic ez, eo;
        model(ta, tb_v, eq, er, ez, eo);
        exp_lat = (tb_v == 8'd0) ? 1 : 9;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        cyc = 0; busy_n = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy) busy_n++;
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy"}, busy_n, exp_lat + 1);
        check({tag, " quo"}, quo, eq);
        check({tag, " rem"}, rem, er);
        check({tag, " dz"}, dz, ez);
        check({tag, " ovl"}, ovl, eo);
        @(posedge clk); #1;
        check({tag, " done pulse"}, {busy, done}, 2'b00);
        check({tag, " hold quo"}, quo, eq);
        check({tag, " hold rem"}, rem, er);
    endtask

    initial begin
        int done_at[$];
        int t;
        logic [7:0] ra, rb;

        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        #1;
        check("reset outputs", {quo, rem, busy, done, dz, ovl}, 20'd0);
        @(negedge clk); rst = 1'b0;

        run_op(8'd200, 8'd7, "200/7");
        run_op(8'd255, 8'd1, "255/1");
        run_op(8'd5, 8'd9, "5/9");
        run_op(8'd37, 8'd0, "37/0");
        run_op(8'd0, 8'd255, "0/255");
        run_op(8'd255, 8'd255, "255/255");
`ifdef DIV_SIGNED_EN
        run_op(8'h9C, 8'd7, "s -100/7");
        run_op(8'h80, 8'hFF, "s -128/-1");
        run_op(8'h64, 8'hF9, "s 100/-7");
`endif

        // start held high: back-to-back results with a scrambled while busy
        b = 8'd10; a = 8'd100; start = 1'b1;
        for (t = 0; t < 34; t++) begin
            @(posedge clk); #1;
            if (done) begin
                done_at.push_back(t);
                check("held quo", quo, 8'd10);
                check("held rem", rem, 8'd0);
            end
            a = busy ? 8'($urandom) : 8'd100;
        end
        start = 1'b0;
        check("held count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("held spacing 1", done_at[1] - done_at[0], 11);
            check("held spacing 2", done_at[2] - done_at[1], 11);
        end
        while (busy && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check("held idle", busy, 1'b0);

        // asynchronous reset on RUN cycle 4
        a = 8'd77; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre-reset busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async reset outputs", {quo, rem, busy, done, dz, ovl}, 20'd0);
        @(negedge clk); rst = 1'b0;
        run_op(8'd77, 8'd3, "post-reset 77/3");

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, $sformatf("rand%0d %0h/%0h", i, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
